// File: rtl/uart_pkg.sv
// uart_pkg: shared FSM state type and constants for the UART transmit path.
//   Exports state_t (IDLE, START, DATA, PARITY, STOP), the PARITY_* mode codes
//   and the default bit period for a 50 MHz clock at 115200 baud.
package uart_pkg;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
  localparam int PARITY_NONE = 0;
  localparam int PARITY_ODD = 1;
  localparam int PARITY_EVEN = 2;
  localparam int CLKS_PER_BIT_50M_115200 = 434;
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with occupancy count.
//   clk, rst (async, active-low); wr_en/wr_data write when not full;
//   rd_en pops when not empty; rd_data shows the head word;
//   full, empty and count report occupancy.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic wr, rd;
  assign wr = wr_en && !full;
  assign rd = rd_en && !empty;
  assign full = count == CW'(DEPTH);
  assign empty = count == '0;
  assign rd_data = mem[rd_ptr];
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      if (wr) wr_ptr <= wr_ptr + AW'(1);
      if (rd) rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(wr) - CW'(rd);
    end
  end
  always_ff @(posedge clk) begin
    if (wr) mem[wr_ptr] <= wr_data;
  end
endmodule

// File: rtl/uart_txd_fifo.sv
// uart_txd_fifo: FIFO-buffered UART transmitter with configurable framing.
//   clk, rst (async, active-low); data_bus/data_valid/data_ready host write
//   handshake; serial_out UART line (idle high); tx_busy frame in progress;
//   fifo_empty and fifo_count report queued words.
module uart_txd_fifo import uart_pkg::*; #(
  parameter int DATA_BITS = 8,
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_50M_115200,
  parameter int PARITY_MODE = PARITY_NONE,
  parameter int STOP_BITS = 1,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [DATA_BITS-1:0]          data_bus,
  input  logic                          data_valid,
  output logic                          data_ready,
  output logic                          serial_out,
  output logic                          tx_busy,
  output logic                          fifo_empty,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);
  localparam int STOP_CLKS = STOP_BITS * CLKS_PER_BIT;
  localparam int CW = $clog2(STOP_CLKS);
  localparam int BW = $clog2(DATA_BITS);
  if (DATA_BITS < 5 || DATA_BITS > 8 || CLKS_PER_BIT < 2 || PARITY_MODE < 0 || PARITY_MODE > 2 ||
      STOP_BITS < 1 || STOP_BITS > 2 || FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)
  begin : g_bad_param
    $error("uart_txd_fifo: illegal parameter value");
  end
  state_t state, state_nxt;
  logic [CW-1:0] cnt;
  logic [BW-1:0] bit_cnt;
  logic [DATA_BITS-1:0] shift, head;
  logic par, full, pop, done, last_bit;
  sync_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk),
    .rst(rst),
    .wr_en(data_valid),
    .wr_data(data_bus),
    .rd_en(pop),
    .rd_data(head),
    .full(full),
    .empty(fifo_empty),
    .count(fifo_count)
  );
  // The stop phase is one long period covering all stop bits.
  assign done = cnt == CW'((state == STOP ? STOP_CLKS : CLKS_PER_BIT) - 1);
  assign last_bit = bit_cnt == BW'(DATA_BITS - 1);
  assign tx_busy = state != IDLE;
  assign data_ready = !full;
  always_comb begin
    state_nxt = state;
    pop = 1'b0;
    case (state)
      IDLE: begin
        pop = !fifo_empty;
        state_nxt = fifo_empty ? IDLE : START;
      end
      START: state_nxt = done ? DATA : START;
      DATA: state_nxt = (done && last_bit) ? (PARITY_MODE != PARITY_NONE ? PARITY : STOP) : DATA;
      PARITY: state_nxt = done ? STOP : PARITY;
      STOP: begin
        pop = done && !fifo_empty;
        state_nxt = !done ? STOP : (fifo_empty ? IDLE : START);
      end
      default: state_nxt = IDLE;
    endcase
  end
  // serial_out follows the current state one cycle later, keeping the pin registered.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      cnt <= '0;
      bit_cnt <= '0;
      shift <= '0;
      par <= 1'b0;
      serial_out <= 1'b1;
    end else begin
      state <= state_nxt;
      cnt <= (done || state == IDLE) ? '0 : cnt + CW'(1);
      if (pop) begin
        shift <= head;
        par <= ^head ^ (PARITY_MODE == PARITY_ODD);
        bit_cnt <= '0;
      end else if (state == DATA && done) begin
        shift <= shift >> 1;
        bit_cnt <= bit_cnt + BW'(1);
      end
      serial_out <= state == START ? 1'b0 : state == DATA ? shift[0] : state == PARITY ? par : 1'b1;
    end
  end
endmodule

// File: tb/tb_uart_txd_fifo.sv
// tb_uart_txd_fifo: directed self-checking bench for uart_txd_fifo (8N1, 7E2, 8O1 instances).
module tb_uart_txd_fifo;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [2:0] v = '0;
  logic [7:0] d [3];
  logic [2:0] so, busy, rdy, emp;
  logic [4:0] cnt0, cnt1, cnt2;
  int vectors = 0;
  int miscompares = 0;
  int acc;
  logic r, dropped;
  logic [9:0] fr;

  always #5 clk = ~clk;

  uart_txd_fifo #(.DATA_BITS(8), .CLKS_PER_BIT(4), .PARITY_MODE(0), .STOP_BITS(1), .FIFO_DEPTH(16)) u_8n1 (
    .clk(clk), .rst(rst), .data_bus(d[0]), .data_valid(v[0]), .data_ready(rdy[0]),
    .serial_out(so[0]), .tx_busy(busy[0]), .fifo_empty(emp[0]), .fifo_count(cnt0));
  uart_txd_fifo #(.DATA_BITS(7), .CLKS_PER_BIT(4), .PARITY_MODE(2), .STOP_BITS(2), .FIFO_DEPTH(16)) u_7e2 (
    .clk(clk), .rst(rst), .data_bus(d[1][6:0]), .data_valid(v[1]), .data_ready(rdy[1]),
    .serial_out(so[1]), .tx_busy(busy[1]), .fifo_empty(emp[1]), .fifo_count(cnt1));
  uart_txd_fifo #(.DATA_BITS(8), .CLKS_PER_BIT(4), .PARITY_MODE(1), .STOP_BITS(1), .FIFO_DEPTH(16)) u_8o1 (
    .clk(clk), .rst(rst), .data_bus(d[2]), .data_valid(v[2]), .data_ready(rdy[2]),
    .serial_out(so[2]), .tx_busy(busy[2]), .fifo_empty(emp[2]), .fifo_count(cnt2));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] word(input int k);
    return 8'(k * 29 + 5);
  endfunction

  task automatic put(input int s, input logic [7:0] x);
    v[s] = 1'b1;
    d[s] = x;
    @(negedge clk);
    v[s] = 1'b0;
  endtask

  // bits[0] is the start bit; each bit is checked on all four of its cycles.
  task automatic send_check(input string tag, input int s, input logic [7:0] x,
                            input logic [15:0] bits, input int n);
    put(s, x);
    @(negedge clk);
    check({tag, "_lat"}, 32'(so[s]), 32'd1);
    for (int i = 0; i < n; i++)
      for (int c = 0; c < 4; c++) begin
        @(negedge clk);
        check({tag, "_bit"}, 32'(so[s]), 32'(bits[i]));
        if (i == 0 && c == 0) check({tag, "_busy"}, 32'(busy[s]), 32'd1);
      end
    check({tag, "_idle"}, 32'(busy[s]), 32'd0);
  endtask

  initial begin
    for (int s = 0; s < 3; s++) d[s] = '0;
    repeat (3) @(negedge clk);
    for (int s = 0; s < 3; s++) begin
      check("rst_line", 32'(so[s]), 32'd1);
      check("rst_busy", 32'(busy[s]), 32'd0);
      check("rst_ready", 32'(rdy[s]), 32'd1);
      check("rst_empty", 32'(emp[s]), 32'd1);
    end
    check("rst_cnt0", 32'(cnt0), 32'd0);
    check("rst_cnt1", 32'(cnt1), 32'd0);
    check("rst_cnt2", 32'(cnt2), 32'd0);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    send_check("8n1_a5", 0, 8'hA5, 16'({1'b1, 8'hA5, 1'b0}), 10);
    send_check("7e2_03", 1, 8'h03, 16'({2'b11, 1'b0, 7'h03, 1'b0}), 11);
    send_check("8o1_00", 2, 8'h00, 16'({1'b1, 1'b1, 8'h00, 1'b0}), 11);
    send_check("8o1_01", 2, 8'h01, 16'({1'b1, 1'b0, 8'h01, 1'b0}), 11);

    acc = 0;
    dropped = 1'b0;
    fork
      begin
        for (int c = 0; c < 1500 && acc < 20; c++) begin
          r = rdy[0];
          if (!r && !dropped) begin
            dropped = 1'b1;
            check("burst_acc_at_full", 32'(acc), 32'd17);
            check("burst_cnt_at_full", 32'(cnt0), 32'd16);
          end
          d[0] = word(acc);
          v[0] = 1'b1;
          @(negedge clk);
          if (r) acc++;
        end
        v[0] = 1'b0;
        check("burst_total", 32'(acc), 32'd20);
        check("burst_full_seen", 32'(dropped), 32'd1);
      end
      begin
        @(negedge clk);
        check("b2b_lat0", 32'(so[0]), 32'd1);
        @(negedge clk);
        check("b2b_lat1", 32'(so[0]), 32'd1);
        for (int j = 0; j < 20; j++) begin
          fr = {1'b1, word(j), 1'b0};
          for (int i = 0; i < 10; i++)
            for (int c = 0; c < 4; c++) begin
              @(negedge clk);
              check("b2b_bit", 32'(so[0]), 32'(fr[i]));
            end
        end
      end
    join
    check("b2b_idle", 32'(busy[0]), 32'd0);
    check("b2b_empty", 32'(emp[0]), 32'd1);

    v[0] = 1'b1;
    d[0] = 8'h11;
    @(negedge clk);
    check("wp_cnt_first", 32'(cnt0), 32'd1);
    d[0] = 8'h22;
    @(negedge clk);
    v[0] = 1'b0;
    check("wp_cnt_net0", 32'(cnt0), 32'd1);
    for (int k = 0; k < 300 && (busy[0] || !emp[0]); k++) @(negedge clk);
    check("wp_drain_busy", 32'(busy[0]), 32'd0);
    check("wp_drain_empty", 32'(emp[0]), 32'd1);
    repeat (2) @(negedge clk);

    v[0] = 1'b1;
    d[0] = 8'h00;
    repeat (2) @(negedge clk);
    v[0] = 1'b0;
    repeat (18) @(negedge clk);
    check("mid_bit3_line", 32'(so[0]), 32'd0);
    check("mid_cnt", 32'(cnt0), 32'd1);
    #1 rst = 1'b0;
    #1;
    check("arst_line", 32'(so[0]), 32'd1);
    check("arst_cnt", 32'(cnt0), 32'd0);
    check("arst_busy", 32'(busy[0]), 32'd0);
    check("arst_ready", 32'(rdy[0]), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      check("post_rst_line", 32'(so[0]), 32'd1);
      check("post_rst_busy", 32'(busy[0]), 32'd0);
    end
    check("post_rst_cnt", 32'(cnt0), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
